// File: rtl/stage_phase_accumulator_pkg.sv
// rtl/stage_phase_accumulator_pkg.sv - shared widths, sideband macros and FSM states for the phase accumulator stage
`ifndef STAGE_PHASE_ACCUMULATOR_DEFS
`define STAGE_PHASE_ACCUMULATOR_DEFS
`define VOICE_OPERATOR_ID 8
`define ALGORITHM_WORD 8
`endif

package stage_phase_accumulator_pkg;

  localparam int PHASE_WIDTH      = 17;
  localparam int MODULATION_WIDTH = 16;

  // S_CLEAR zeroes accumulator state after reset, S_RUN is normal operation
  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/stage_phase_accumulator_slot_ram.sv
// rtl/stage_phase_accumulator_slot_ram.sv - per-slot storage, one write port, one read-first synchronous read port
module slot_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_Clock,
  input  logic                  i_WriteEnable,
  input  logic [ADDR_WIDTH-1:0] i_WriteAddr,
  input  logic [WIDTH-1:0]      i_WriteData,
  input  logic [ADDR_WIDTH-1:0] i_ReadAddr,
  output logic [WIDTH-1:0]      o_ReadData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and read share the edge; a same-address read returns the old word
  always_ff @(posedge i_Clock) begin
    if (i_WriteEnable) begin
      mem[i_WriteAddr] <= i_WriteData;
    end
    o_ReadData <= mem[i_ReadAddr];
  end

endmodule

// File: rtl/stage_phase_accumulator.sv
// rtl/stage_phase_accumulator.sv - three-clock per-slot phase accumulator; PHASE_KEY_SYNC_EN enables note-on key sync
module stage_phase_accumulator
  import stage_phase_accumulator_pkg::*;
#(
  parameter int NUM_SLOTS = 256,
  parameter int ACC_WIDTH = 24
) (
  input  logic                               i_Clock,
  input  logic                               i_Reset_n,
  input  logic [`VOICE_OPERATOR_ID-1:0]      i_VoiceOperator,
  input  logic [`ALGORITHM_WORD-1:0]         i_AlgorithmWord,
  input  logic                               i_NoteOn,
  input  logic signed [MODULATION_WIDTH-1:0] i_Modulation,
  input  logic                               i_StepWriteEnable,
  input  logic [`VOICE_OPERATOR_ID-1:0]      i_StepWriteAddr,
  input  logic [ACC_WIDTH-1:0]               i_StepWriteData,
  output logic [`VOICE_OPERATOR_ID-1:0]      o_VoiceOperator,
  output logic [`ALGORITHM_WORD-1:0]         o_AlgorithmWord,
  output logic                               o_NoteOn,
  output logic signed [PHASE_WIDTH-1:0]      o_Phase,
  output logic                               o_Ready
);

  localparam int SLOT_BITS  = $clog2(NUM_SLOTS);
  localparam int BASE_WIDTH = PHASE_WIDTH - 1;

  state_t                              state;
  logic [SLOT_BITS-1:0]                clearCount;
  logic                                inRun;
  logic [SLOT_BITS-1:0]                readSlot;

  logic                                s1Valid;
  logic [SLOT_BITS-1:0]                s1Slot;
  logic [`VOICE_OPERATOR_ID-1:0]       s1VoiceOperator;
  logic [`ALGORITHM_WORD-1:0]          s1AlgorithmWord;
  logic                                s1NoteOn;
  logic signed [MODULATION_WIDTH-1:0]  s1Modulation;

  logic [ACC_WIDTH-1:0]                accRead;
  logic [ACC_WIDTH-1:0]                stepRead;
  logic [ACC_WIDTH-1:0]                accBase;
  logic [ACC_WIDTH-1:0]                accNext;
  logic                                stateWriteEnable;
  logic [SLOT_BITS-1:0]                stateWriteAddr;
  logic [ACC_WIDTH-1:0]                accWriteData;

  logic [`VOICE_OPERATOR_ID-1:0]       s2VoiceOperator;
  logic [`ALGORITHM_WORD-1:0]          s2AlgorithmWord;
  logic                                s2NoteOn;
  logic signed [MODULATION_WIDTH-1:0]  s2Modulation;
  logic [BASE_WIDTH-1:0]               s2Base;

  assign inRun    = (state == S_RUN);
  assign readSlot = i_VoiceOperator[SLOT_BITS-1:0];

  // Init sweep: one slot cleared per clock, then run until the next reset
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= S_CLEAR;
      clearCount <= '0;
      o_Ready    <= 1'b0;
    end else if (state == S_CLEAR) begin
      clearCount <= clearCount + 1'b1;
      if (clearCount == SLOT_BITS'(NUM_SLOTS - 1)) begin
        state   <= S_RUN;
        o_Ready <= 1'b1;
      end
    end
  end

  // During the sweep the write port belongs to the clear counter; afterwards to stage 2
  assign stateWriteEnable = inRun ? s1Valid : 1'b1;
  assign stateWriteAddr   = inRun ? s1Slot : clearCount;
  assign accNext          = accBase + stepRead;
  assign accWriteData     = inRun ? accNext : '0;

  slot_ram #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (NUM_SLOTS)
  ) u_accRam (
    .i_Clock       (i_Clock),
    .i_WriteEnable (stateWriteEnable),
    .i_WriteAddr   (stateWriteAddr),
    .i_WriteData   (accWriteData),
    .i_ReadAddr    (readSlot),
    .o_ReadData    (accRead)
  );

  slot_ram #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (NUM_SLOTS)
  ) u_stepRam (
    .i_Clock       (i_Clock),
    .i_WriteEnable (i_StepWriteEnable),
    .i_WriteAddr   (i_StepWriteAddr[SLOT_BITS-1:0]),
    .i_WriteData   (i_StepWriteData),
    .i_ReadAddr    (readSlot),
    .o_ReadData    (stepRead)
  );

`ifdef PHASE_KEY_SYNC_EN
  logic prevNoteRead;
  logic noteRise;

  slot_ram #(
    .WIDTH (1),
    .DEPTH (NUM_SLOTS)
  ) u_prevNoteRam (
    .i_Clock       (i_Clock),
    .i_WriteEnable (stateWriteEnable),
    .i_WriteAddr   (stateWriteAddr),
    .i_WriteData   (inRun & s1NoteOn),
    .i_ReadAddr    (readSlot),
    .o_ReadData    (prevNoteRead)
  );

  assign noteRise = s1NoteOn & ~prevNoteRead;
  assign accBase  = noteRise ? '0 : accRead;
`else
  assign accBase  = accRead;
`endif

  // Stage 1: capture slot and sideband alongside the RAM reads; zeros while sweeping
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      s1Valid         <= 1'b0;
      s1Slot          <= '0;
      s1VoiceOperator <= '0;
      s1AlgorithmWord <= '0;
      s1NoteOn        <= 1'b0;
      s1Modulation    <= '0;
    end else if (inRun) begin
      s1Valid         <= 1'b1;
      s1Slot          <= readSlot;
      s1VoiceOperator <= i_VoiceOperator;
      s1AlgorithmWord <= i_AlgorithmWord;
      s1NoteOn        <= i_NoteOn;
      s1Modulation    <= i_Modulation;
    end else begin
      s1Valid         <= 1'b0;
      s1Slot          <= '0;
      s1VoiceOperator <= '0;
      s1AlgorithmWord <= '0;
      s1NoteOn        <= 1'b0;
      s1Modulation    <= '0;
    end
  end

  // Stage 2: hold the pre-increment phase base; bubbles carry a zero base
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      s2VoiceOperator <= '0;
      s2AlgorithmWord <= '0;
      s2NoteOn        <= 1'b0;
      s2Modulation    <= '0;
      s2Base          <= '0;
    end else begin
      s2VoiceOperator <= s1VoiceOperator;
      s2AlgorithmWord <= s1AlgorithmWord;
      s2NoteOn        <= s1NoteOn;
      s2Modulation    <= s1Modulation;
      s2Base          <= s1Valid ? accBase[ACC_WIDTH-1 -: BASE_WIDTH] : '0;
    end
  end

  // Stage 3: add sign-extended modulation to the base, wrapping at 17 bits
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_VoiceOperator <= '0;
      o_AlgorithmWord <= '0;
      o_NoteOn        <= 1'b0;
      o_Phase         <= '0;
    end else begin
      o_VoiceOperator <= s2VoiceOperator;
      o_AlgorithmWord <= s2AlgorithmWord;
      o_NoteOn        <= s2NoteOn;
      o_Phase         <= {1'b0, s2Base} + {s2Modulation[MODULATION_WIDTH-1], s2Modulation};
    end
  end

endmodule

// File: doc/stage_phase_accumulator.md
# stage_phase_accumulator

Per-slot phase accumulator stage that sits directly upstream of the waveform generator and produces the 17-bit signed phase it consumes. Each cycle it handles one time-multiplexed voice/operator slot: it reads that slot's accumulator and phase step, advances the accumulator and adds the incoming modulation. The modulated phase and the slot's sideband (voice/operator ID, algorithm word, note-on) leave together, three clocks later. After reset, an init sweep zeroes all accumulator state before the stage reports ready.

## Interface
- NUM_SLOTS, 256: number of voice/operator slots. Must be a power of two and ≥ 4.
- ACC_WIDTH, 24: accumulator width in bits. Output phase base is acc[ACC_WIDTH-1 -: 16].
- i_Clock  in  1  sole clock.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_VoiceOperator  in  `VOICE_OPERATOR_ID  slot being processed this cycle.
- i_AlgorithmWord  in  `ALGORITHM_WORD  sideband, passed through.
- i_NoteOn  in  1  gate for this slot, passed through.
- i_Modulation  in  signed 16  modulator output added to the phase.
- i_StepWriteEnable  in  1  phase-step RAM write strobe.
- i_StepWriteAddr  in  `VOICE_OPERATOR_ID  slot to write.
- i_StepWriteData  in  ACC_WIDTH  unsigned phase increment per visit.
- o_VoiceOperator, o_AlgorithmWord, o_NoteOn  out  same widths  delayed sideband.
- o_Phase  out  signed 17  modulated phase, sent to the waveform generator.
- o_Ready  out  1  high once the init sweep is complete.

## Operation
- FSM states:
  - S_CLEAR (entered on reset): a counter runs 0..NUM_SLOTS-1 and writes 0 to each accumulator entry and each previous-note-on bit, one per cycle. When the counter reaches NUM_SLOTS-1, go to S_RUN.
  - S_RUN: normal operation; stays here until reset.
- In S_CLEAR:
  - Slot inputs are ignored.
  - o_NoteOn = 0, o_Phase = 0.
  - Phase-step writes are still accepted.
- Clock 1: read acc[slot], step[slot] and prevNote[slot]. Register i_Modulation and the sideband.
- Clock 2:
  - rise = NoteOn & ~prevNote (only with the macro; see Configuration).
  - base = rise ? 0 : acc.
  - Write acc[slot] = base + step, modulo 2^ACC_WIDTH (wraps silently).
  - Write prevNote[slot] = NoteOn.
  - Register base[ACC_WIDTH-1 -: 16].
- Clock 3: o_Phase = {1'b0, base16} + sign-extended modulation, truncated to 17 bits (two's-complement wrap).
  - The output is the pre-increment phase, so the first visit after a note-on outputs phase 0 + modulation.
- Step-RAM write/read collision on the same slot in the same cycle: the read returns the old value. The new step takes effect on the next visit.
- Same-slot read-after-write hazard cannot occur because each slot recurs every NUM_SLOTS ≥ 4 cycles. No bypass is required.
- The step RAM is not cleared by reset; software rewrites it after boot.

## Timing
- Latency: 3 clocks from slot inputs to outputs, and the same for sideband and phase. Throughput is one slot per clock.
- Reset values: all outputs and pipeline registers are 0, including o_Ready = 0. The FSM resets to S_CLEAR with its counter at 0.
- o_Ready rises on the clock that enters S_RUN, exactly NUM_SLOTS clocks after i_Reset_n deasserts. The first valid output appears 3 clocks later.
- Reset asserted mid-sweep or mid-run:
  - Immediately clears the registers (asynchronous).
  - Restarts the sweep from slot 0 on deassertion.
  - Pipeline contents in flight are discarded.

## Configuration
- PHASE_KEY_SYNC_EN:
  - Defined: a rising edge of a slot's note-on (prevNote = 0, NoteOn = 1) zeroes that slot's accumulator before the increment.
  - Undefined: accumulators free-run; the prevNote RAM and rise logic are compiled out, and note-on only passes through.

## Structure
- The shared synth package/header holds:
  - the slot ID and algorithm word width macros;
  - PHASE_WIDTH = 17 and MODULATION_WIDTH = 16;
  - the FSM state enum.
- One sub-module, slot_ram: single write port and single synchronous read port, parameterised width and depth, with no reset. It is instantiated for accumulator, step and prevNote storage.

## Test plan
- Reset release, slots cycling 0..255 -> o_Ready low for 256 clocks then high; o_NoteOn and o_Phase stay 0 throughout the sweep.
- Step[5] = 0x000100, modulation 0, NoteOn = 1 -> slot 5 outputs phase 0, 1, 2, 3 on successive visits, 3 clocks after each input.
- Step[7] = 0xFFFF00, acc starting at 0 -> o_Phase sequence for slot 7 is 0x0000, 0xFFFF, 0xFFFE (acc wraps, bit 16 = 0).
- Phase base 0x0010 with modulation -32 -> o_Phase = 0x1FFF0 (17-bit wrap).
- Key sync, macro defined: slot 3 accumulated to 0x4000, NoteOn 0→1 -> next output phase 0. With the macro undefined -> output continues from 0x4000 plus step.
- Step write to slot 9 in the same cycle slot 9 is read -> that visit uses the old step; the next visit uses the new one.
